// File: rtl/sync_fifo_flags_if.sv
// rtl/sync_fifo_flags_if.sv - producer/consumer signal bundle for sync_fifo_flags
interface sync_fifo_flags_if #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_WIDTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                  i_wen;
  logic [FIFO_WIDTH-1:0] i_wdata;
  logic                  o_full;
  logic                  o_afull;
  logic                  i_ren;
  logic [FIFO_WIDTH-1:0] o_rdata;
  logic                  o_rempty;
  logic                  o_aempty;
  logic [CNT_W-1:0]      o_count;
  logic                  o_overflow;
  logic                  o_underflow;
  logic                  i_clr_err;

  // Side that drives requests and consumes status (producer/consumer logic)
  modport master (
    output i_wen, i_wdata, i_ren, i_clr_err,
    input  o_full, o_afull, o_rdata, o_rempty, o_aempty, o_count, o_overflow, o_underflow
  );

  // The FIFO itself
  modport slave (
    input  i_wen, i_wdata, i_ren, i_clr_err,
    output o_full, o_afull, o_rdata, o_rempty, o_aempty, o_count, o_overflow, o_underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with count, threshold and sticky error flags
module sync_fifo_flags #(
  parameter int FIFO_DEPTH    = 16,
  parameter int FIFO_WIDTH    = 4,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 4,
  parameter int FWFT          = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  sync_fifo_flags_if.slave  bus
);
  localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
  localparam logic [PTR_WIDTH:0] DEPTH_C  = (PTR_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [PTR_WIDTH:0] AFULL_C  = (PTR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [PTR_WIDTH:0] AEMPTY_C = (PTR_WIDTH+1)'(AEMPTY_THRESH);
  localparam logic [PTR_WIDTH:0] ONE_C    = (PTR_WIDTH+1)'(1);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [PTR_WIDTH:0]    wptr_q, wptr_d;
  logic [PTR_WIDTH:0]    rptr_q, rptr_d;
  logic [PTR_WIDTH:0]    count_q, count_d;
  logic [FIFO_WIDTH-1:0] rdata_q, rdata_d;
  logic                  valid_q, valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic full, rempty, wr_acc, rd_acc, mem_empty, load;

  // Next-state: acceptance, pointers, head/read register, occupancy and error flags
  always_comb begin
    full      = (count_q == DEPTH_C);
    rempty    = (FWFT != 0) ? ~valid_q : (count_q == '0);
    wr_acc    = bus.i_wen & ~full;
    rd_acc    = bus.i_ren & ~rempty;
    // In FWFT mode memory holds count minus the head word, so its own emptiness
    // comes from the pointers rather than from count.
    mem_empty = (wptr_q == rptr_q);
    load      = 1'b0;

    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    rdata_d   = rdata_q;
    valid_d   = valid_q;
    count_d   = count_q;

    if (wr_acc) wptr_d = wptr_q + ONE_C;

    if (FWFT != 0) begin
      // Refill the head whenever it is empty or being popped, so pops run back to back
      load = (~valid_q | rd_acc) & ~mem_empty;
      if (load) begin
        rdata_d = mem[rptr_q[PTR_WIDTH-1:0]];
        rptr_d  = rptr_q + ONE_C;
        valid_d = 1'b1;
      end else if (rd_acc) begin
        valid_d = 1'b0;
      end
    end else begin
      valid_d = 1'b0;
      if (rd_acc) begin
        rdata_d = mem[rptr_q[PTR_WIDTH-1:0]];
        rptr_d  = rptr_q + ONE_C;
      end
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase

    // A set event in the same cycle as a clear leaves the flag set
    overflow_d  = (bus.i_wen & full)   | (overflow_q  & ~bus.i_clr_err);
    underflow_d = (bus.i_ren & rempty) | (underflow_q & ~bus.i_clr_err);
  end

  // Control state with asynchronous reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      rdata_q     <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      rdata_q     <= rdata_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array, deliberately left unreset
  always_ff @(posedge i_clk) begin
    if (wr_acc) mem[wptr_q[PTR_WIDTH-1:0]] <= bus.i_wdata;
  end

  assign bus.o_full      = full;
  assign bus.o_afull     = (count_q >= AFULL_C);
  assign bus.o_aempty    = (count_q <= AEMPTY_C);
  assign bus.o_rempty    = rempty;
  assign bus.o_count     = count_q;
  assign bus.o_rdata     = rdata_q;
  assign bus.o_overflow  = overflow_q;
  assign bus.o_underflow = underflow_q;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - self-checking bench for sync_fifo_flags in standard and FWFT modes
module tb_sync_fifo_flags;
  localparam int DEPTH = 16;
  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_flags_if #(.FIFO_DEPTH(DEPTH), .FIFO_WIDTH(WIDTH)) bus_s ();
  sync_fifo_flags_if #(.FIFO_DEPTH(DEPTH), .FIFO_WIDTH(WIDTH)) bus_f ();

  sync_fifo_flags #(.FIFO_DEPTH(DEPTH), .FIFO_WIDTH(WIDTH), .AFULL_THRESH(12),
                    .AEMPTY_THRESH(4), .FWFT(0)) u_std (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_s));
  sync_fifo_flags #(.FIFO_DEPTH(DEPTH), .FIFO_WIDTH(WIDTH), .AFULL_THRESH(12),
                    .AEMPTY_THRESH(4), .FWFT(1)) u_fwft (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_f));

  typedef struct {
    logic       wen;
    logic [3:0] wd;
    logic       ren;
    logic       clr;
    int         cnt;
    logic       ovf;
  } vec_t;

  vec_t       tbl[$];
  logic [3:0] sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         m_cnt = 0;
  logic [3:0] exp_d;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc_s(input logic wen, input logic [3:0] wd, input logic ren, input logic clr);
    bus_s.i_wen = wen; bus_s.i_wdata = wd; bus_s.i_ren = ren; bus_s.i_clr_err = clr;
    @(posedge clk); #1;
    bus_s.i_wen = 1'b0; bus_s.i_ren = 1'b0; bus_s.i_clr_err = 1'b0;
  endtask

  task automatic cyc_f(input logic wen, input logic [3:0] wd, input logic ren, input logic clr);
    bus_f.i_wen = wen; bus_f.i_wdata = wd; bus_f.i_ren = ren; bus_f.i_clr_err = clr;
    @(posedge clk); #1;
    bus_f.i_wen = 1'b0; bus_f.i_ren = 1'b0; bus_f.i_clr_err = 1'b0;
  endtask

  // Flag decode expected from the count: full at 16, afull at >=12, aempty at <=4
  task automatic flags_s(input string nm, input int cnt);
    chk({nm, "_count"},  32'(bus_s.o_count), 32'(cnt));
    chk({nm, "_full"},   32'(bus_s.o_full),   32'(cnt == 16));
    chk({nm, "_afull"},  32'(bus_s.o_afull),  32'(cnt >= 12));
    chk({nm, "_aempty"}, 32'(bus_s.o_aempty), 32'(cnt <= 4));
    chk({nm, "_rempty"}, 32'(bus_s.o_rempty), 32'(cnt == 0));
  endtask

  task automatic rd_s(input string nm);
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp_d = sb.pop_front();
      cyc_s(1'b0, 4'h0, 1'b1, 1'b0);
      chk({nm, "_rdata"}, 32'(bus_s.o_rdata), 32'(exp_d));
    end
  endtask

  task automatic reset_vals(input string nm);
    chk({nm, "_count"},  32'(bus_s.o_count), 32'd0);
    chk({nm, "_rempty"}, 32'(bus_s.o_rempty), 32'd1);
    chk({nm, "_aempty"}, 32'(bus_s.o_aempty), 32'd1);
    chk({nm, "_full"},   32'(bus_s.o_full),   32'd0);
    chk({nm, "_afull"},  32'(bus_s.o_afull),  32'd0);
    chk({nm, "_rdata"},  32'(bus_s.o_rdata),  32'd0);
    chk({nm, "_ovf"},    32'(bus_s.o_overflow),  32'd0);
    chk({nm, "_udf"},    32'(bus_s.o_underflow), 32'd0);
    chk({nm, "_f_rempty"}, 32'(bus_f.o_rempty), 32'd1);
    chk({nm, "_f_count"},  32'(bus_f.o_count),  32'd0);
  endtask

  initial begin
    bus_s.i_wen = 1'b0; bus_s.i_wdata = '0; bus_s.i_ren = 1'b0; bus_s.i_clr_err = 1'b0;
    bus_f.i_wen = 1'b0; bus_f.i_wdata = '0; bus_f.i_ren = 1'b0; bus_f.i_clr_err = 1'b0;

    // Vector table: fill 0x0..0xF, one rejected write, then clear the error
    for (int i = 0; i < 16; i++) tbl.push_back('{1'b1, 4'(i), 1'b0, 1'b0, i + 1, 1'b0});
    tbl.push_back('{1'b1, 4'h5, 1'b0, 1'b0, 16, 1'b1});
    tbl.push_back('{1'b0, 4'h0, 1'b0, 1'b1, 16, 1'b0});

    repeat (3) @(posedge clk);
    #1;
    reset_vals("rst");
    rst_n = 1'b1;

    // Standard mode: table-driven fill / overflow / clear
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].wen && m_cnt < 16) begin
        sb.push_back(tbl[i].wd);
        m_cnt++;
      end
      cyc_s(tbl[i].wen, tbl[i].wd, tbl[i].ren, tbl[i].clr);
      flags_s($sformatf("fill%0d", i), tbl[i].cnt);
      chk($sformatf("fill%0d_ovf", i), 32'(bus_s.o_overflow), 32'(tbl[i].ovf));
    end

    // Drain: data in order, one cycle after each read edge
    for (int i = 0; i < 16; i++) begin
      rd_s($sformatf("drain%0d", i));
      flags_s($sformatf("drain%0d", i), 15 - i);
    end
    m_cnt = 0;
    cyc_s(1'b0, 4'h0, 1'b1, 1'b0);
    chk("udf_set",   32'(bus_s.o_underflow), 32'd1);
    chk("udf_rdata", 32'(bus_s.o_rdata),     32'hF);
    chk("udf_count", 32'(bus_s.o_count),     32'd0);
    cyc_s(1'b0, 4'h0, 1'b1, 1'b1);
    chk("udf_set_wins", 32'(bus_s.o_underflow), 32'd1);
    cyc_s(1'b0, 4'h0, 1'b0, 1'b1);
    chk("udf_clear", 32'(bus_s.o_underflow), 32'd0);

    // Simultaneous access on empty: write wins, read flagged
    sb.push_back(4'h7);
    cyc_s(1'b1, 4'h7, 1'b1, 1'b0);
    flags_s("sim_empty", 1);
    chk("sim_empty_udf", 32'(bus_s.o_underflow), 32'd1);
    for (int i = 0; i < 15; i++) begin
      sb.push_back(4'(i + 8));
      cyc_s(1'b1, 4'(i + 8), 1'b0, 1'b0);
    end
    flags_s("refill", 16);

    // Simultaneous access on full: read accepted, write rejected
    exp_d = sb.pop_front();
    cyc_s(1'b1, 4'h9, 1'b1, 1'b0);
    chk("sim_full_rdata", 32'(bus_s.o_rdata), 32'(exp_d));
    chk("sim_full_ovf",   32'(bus_s.o_overflow), 32'd1);
    flags_s("sim_full", 15);

    for (int i = 0; i < 12; i++) rd_s($sformatf("down%0d", i));
    flags_s("at3", 3);

    // Sustained read+write with count held at 3; pointers wrap several times
    for (int k = 0; k < 100; k++) begin
      sb.push_back(4'(k * 7 + 1));
      exp_d = sb.pop_front();
      cyc_s(1'b1, 4'(k * 7 + 1), 1'b1, 1'b0);
      chk($sformatf("wrap%0d_rdata", k), 32'(bus_s.o_rdata), 32'(exp_d));
      flags_s($sformatf("wrap%0d", k), 3);
    end

    // Asynchronous reset mid-transfer
    bus_s.i_wen = 1'b1; bus_s.i_ren = 1'b1; bus_s.i_wdata = 4'hC;
    #3 rst_n = 1'b0;
    #1 reset_vals("mid_rst");
    bus_s.i_wen = 1'b0; bus_s.i_ren = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // FWFT: write into empty, head visible one edge later
    cyc_f(1'b1, 4'hA, 1'b0, 1'b0);
    chk("fwft_n_count",  32'(bus_f.o_count),  32'd1);
    chk("fwft_n_rempty", 32'(bus_f.o_rempty), 32'd1);
    cyc_f(1'b0, 4'h0, 1'b0, 1'b0);
    chk("fwft_n1_rdata",  32'(bus_f.o_rdata),  32'hA);
    chk("fwft_n1_rempty", 32'(bus_f.o_rempty), 32'd0);
    cyc_f(1'b1, 4'hB, 1'b0, 1'b0);
    chk("fwft_b_count", 32'(bus_f.o_count), 32'd2);
    chk("fwft_b_head",  32'(bus_f.o_rdata), 32'hA);
    cyc_f(1'b0, 4'h0, 1'b1, 1'b0);
    chk("fwft_pop_rdata",  32'(bus_f.o_rdata),  32'hB);
    chk("fwft_pop_rempty", 32'(bus_f.o_rempty), 32'd0);
    chk("fwft_pop_count",  32'(bus_f.o_count),  32'd1);
    cyc_f(1'b0, 4'h0, 1'b1, 1'b0);
    chk("fwft_last_rempty", 32'(bus_f.o_rempty), 32'd1);
    chk("fwft_last_count",  32'(bus_f.o_count),  32'd0);
    cyc_f(1'b0, 4'h0, 1'b1, 1'b0);
    chk("fwft_udf", 32'(bus_f.o_underflow), 32'd1);
    cyc_f(1'b0, 4'h0, 1'b0, 1'b1);
    chk("fwft_udf_clr", 32'(bus_f.o_underflow), 32'd0);

    // FWFT capacity and back-to-back pops
    for (int i = 0; i < 16; i++) begin
      sb.push_back(4'(i + 3));
      cyc_f(1'b1, 4'(i + 3), 1'b0, 1'b0);
    end
    chk("fwft_full_count", 32'(bus_f.o_count), 32'd16);
    chk("fwft_full",       32'(bus_f.o_full),  32'd1);
    cyc_f(1'b1, 4'h0, 1'b0, 1'b0);
    chk("fwft_ovf",       32'(bus_f.o_overflow), 32'd1);
    chk("fwft_ovf_count", 32'(bus_f.o_count),    32'd16);
    for (int i = 0; i < 16; i++) begin
      exp_d = sb.pop_front();
      chk($sformatf("fwft_head%0d", i),   32'(bus_f.o_rdata),  32'(exp_d));
      chk($sformatf("fwft_rempty%0d", i), 32'(bus_f.o_rempty), 32'd0);
      cyc_f(1'b0, 4'h0, 1'b1, 1'b0);
      chk($sformatf("fwft_cnt%0d", i), 32'(bus_f.o_count), 32'(15 - i));
    end
    chk("fwft_drained", 32'(bus_f.o_rempty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
